mac_seq: RTL
============

// Module: mac_seq
// PURPOSE
//  Initiator for the mac block: accepts a dot-product job, streams operand pairs into mac,
//  generates the instruction sequence (load, accumulate, optional saturate) and captures the
//  final {protect,result} for a downstream consumer. Sits between the operand buffer and mac.
// PARAMETERS
//  LEN_W    8  width of job_len (max pairs per job = 2**LEN_W-1)
//  MAC_LAT  2  cycles from instruction issue to its effect on mac {protect,result}
// PORTS
//  clk              in   1   clock; all logic on rising edge
//  reset            in   1   synchronous, active-high reset
//  job_valid        in   1   job descriptor valid
//  job_ready        out  1   job accepted when job_valid&&job_ready
//  job_len          in   LEN_W number of operand pairs
//  job_mode         in   1   0: 16x16 signed; 1: dual-lane 8x8 signed
//  job_sat          in   1   1: append saturate step before capture
//  op_valid         in   1   operand pair valid
//  op_ready         out  1   pair consumed when op_valid&&op_ready
//  op_a, op_b       in   16  signed operands
//  mac_instruction  out  3   {mode, op[1:0]}; op 00 clear, 01 load, 10 accumulate, 11 saturate
//  mac_multiplier   out  16  to mac multiplier
//  mac_multiplicand out  16  to mac multiplicand
//  mac_stall        out  1   freezes mac pipeline for the cycle
//  mac_result       in   32  from mac result
//  mac_protect      in   8   from mac protect
//  res_valid        out  1   job result valid
//  res_ready        in   1   result consumed when res_valid&&res_ready
//  res_result       out  32  captured mac_result
//  res_protect      out  8   captured mac_protect
//  busy             out  1   high in every state except IDLE
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (mac_instruction=3'b000, mac_stall=0, res_*=0).
//  FSM IDLE->CLR->RUN->[SAT]->DRAIN->DONE->IDLE.
//  IDLE: job_ready=1; on accept latch len/mode/sat, go CLR.
//  CLR: issue {mode,00} for 1 cycle; len==0 -> DRAIN, else RUN.
//  RUN: op_ready=1. First pair issued as {mode,01}, later pairs {mode,10}, operands driven
//   the same cycle. If op_valid=0: mac_stall=1, instruction/operands hold last values;
//   stall never asserted outside RUN. After last pair: sat ? SAT : DRAIN.
//  SAT: issue {mode,11} one cycle, go DRAIN.
//  DRAIN: issue {mode,00}? no: drive instruction {mode,01} is forbidden; drive last
//   instruction op as 11 if sat else 10 with operands 0 (adds zero), for MAC_LAT cycles;
//   then sample mac_protect/mac_result into res_*, go DONE.
//  DONE: res_valid=1, res_* stable until res_ready; then IDLE (job_ready next cycle).
//  Dual mode lane mapping (mac-defined): op[7:0] products -> result[31:16], protect[7:4];
//   op[15:8] products -> result[15:0], protect[3:0].
//  No new job accepted until DONE handshake completes; job_valid ignored otherwise.
//  Reset asserted in any state: next cycle IDLE, outputs at reset values, partial job dropped.
//  Pair counter LEN_W bits, counts down, no wrap (terminates at 0).
// STRUCTURE
//  mac_pkg: opcode localparams (OP_CLR/LOAD/ACC/SAT), mode bit, state enum, MAC_LAT default.
//  One sub-module: mac_issue_reg (instruction/operand output register with stall-hold).
// TESTING
//  16-bit, len=3, pairs (2,3),(4,5),(-1,6), sat=0 -> res_result=0x00000014, res_protect=0x00.
//  16-bit, len=3, three pairs (0x7FFF,0x7FFF), sat=1 -> res_result=0x7FFFFFFF.
//  Dual, len=1, a=0x0203 b=0x0405 -> res_result=0x000F0008, res_protect=0x00.
//  len=4 with op_valid low 2 cycles after pair 2 -> mac_stall high exactly 2 cycles, result unchanged vs no-bubble run.
//  len=0 -> CLR then DRAIN, res_result=0, res_protect=0; res_ready held low 5 cycles -> res_* stable, job_ready=0.
//  reset in RUN after pair 1 -> next cycle IDLE, all outputs 0; following job len=1 (3,3) -> 9.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the mac sequencer: opcodes, mode bit, FSM states
// and the default mac pipeline latency.
package mac_pkg;

  // mac opcodes carried in mac_instruction[1:0]
  localparam logic [1:0] OP_CLR  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_ACC  = 2'b10;
  localparam logic [1:0] OP_SAT  = 2'b11;

  // mac_instruction[2]: 0 = one 16x16 signed lane, 1 = two 8x8 signed lanes
  localparam logic MODE_WIDE = 1'b0;
  localparam logic MODE_DUAL = 1'b1;

  // Cycles between an instruction appearing on the mac inputs and its
  // effect showing on {mac_protect, mac_result}
  localparam int MAC_LAT_DEFAULT = 2;

  // Operand width on the mac multiplier/multiplicand inputs
  localparam int OPND_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_RUN   = 3'd2,
    ST_SAT   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } seq_state_t;

  // Pack a mode bit and an opcode into the 3-bit mac instruction
  function automatic logic [2:0] mac_instr(input logic mode, input logic [1:0] op);
    return {mode, op};
  endfunction

endpackage

// File: rtl/mac_issue_reg.sv
// Output register for the mac instruction and operands. When hold is high
// the previous instruction/operands are kept and stall is raised for that
// cycle, so the frozen mac never sees a pair twice.
module mac_issue_reg
  import mac_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic [2:0]        next_instruction,
  input  logic [OPND_W-1:0] next_multiplier,
  input  logic [OPND_W-1:0] next_multiplicand,
  output logic [2:0]        instruction,
  output logic [OPND_W-1:0] multiplier,
  output logic [OPND_W-1:0] multiplicand,
  output logic              stall
);

  logic [2:0]        instruction_reg;
  logic              stall_reg;
  logic [OPND_W-1:0] opnd_next [2];
  logic [OPND_W-1:0] opnd_q    [2];

  assign opnd_next[0] = next_multiplier;
  assign opnd_next[1] = next_multiplicand;

  // Instruction and stall flag: load a fresh instruction or freeze the old one
  always_ff @(posedge clk) begin
    if (reset) begin
      instruction_reg <= 3'b000;
      stall_reg       <= 1'b0;
    end else if (hold) begin
      stall_reg       <= 1'b1;
    end else begin
      instruction_reg <= next_instruction;
      stall_reg       <= 1'b0;
    end
  end

  // One identical register per operand channel (multiplier, multiplicand)
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_opnd
      logic [OPND_W-1:0] lane_reg;

      // Operand capture, frozen together with the instruction
      always_ff @(posedge clk) begin
        if (reset) begin
          lane_reg <= '0;
        end else if (!hold) begin
          lane_reg <= opnd_next[gi];
        end
      end

      assign opnd_q[gi] = lane_reg;
    end
  endgenerate

  assign instruction  = instruction_reg;
  assign stall        = stall_reg;
  assign multiplier   = opnd_q[0];
  assign multiplicand = opnd_q[1];

endmodule

// File: rtl/mac_seq.sv
// Dot-product job initiator for the mac block. Accepts a job descriptor,
// streams operand pairs into mac as clear / load / accumulate (/ saturate),
// waits out the mac latency and holds the final {protect,result} until the
// consumer takes it.
module mac_seq
  import mac_pkg::*;
#(
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = MAC_LAT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [LEN_W-1:0]  job_len,
  input  logic              job_mode,
  input  logic              job_sat,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [OPND_W-1:0] op_a,
  input  logic [OPND_W-1:0] op_b,
  output logic [2:0]        mac_instruction,
  output logic [OPND_W-1:0] mac_multiplier,
  output logic [OPND_W-1:0] mac_multiplicand,
  output logic              mac_stall,
  input  logic [31:0]       mac_result,
  input  logic [7:0]        mac_protect,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_result,
  output logic [7:0]        res_protect,
  output logic              busy
);

  // The issue register adds one cycle, so the last real instruction reaches
  // mac one cycle after the FSM leaves RUN/SAT; DRAIN therefore lasts
  // MAC_LAT+1 cycles before the result is sampled.
  localparam int              DRAIN_W    = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(MAC_LAT);

  seq_state_t         state_reg;
  logic [LEN_W-1:0]   cnt_reg;
  logic               mode_reg;
  logic               sat_reg;
  logic               first_reg;
  logic [DRAIN_W-1:0] drain_cnt_reg;
  logic               job_ready_reg;
  logic               op_ready_reg;
  logic               res_valid_reg;
  logic [31:0]        res_result_reg;
  logic [7:0]         res_protect_reg;
  logic               busy_reg;

  logic               issue_hold_next;
  logic [2:0]         issue_instruction_next;
  logic [OPND_W-1:0]  issue_multiplier_next;
  logic [OPND_W-1:0]  issue_multiplicand_next;

  logic               job_take;
  logic               op_take;
  logic [1:0]         drain_op;

  assign job_take = (state_reg == ST_IDLE) && job_valid && job_ready_reg;
  assign op_take  = (state_reg == ST_RUN) && op_valid && op_ready_reg;
  // Zero-operand filler: accumulate adds nothing, saturate is idempotent
  assign drain_op = sat_reg ? OP_SAT : OP_ACC;

  // Next instruction/operands for the issue register, derived from the current state
  always_comb begin
    issue_hold_next         = 1'b0;
    issue_instruction_next  = mac_instr(MODE_WIDE, OP_CLR);
    issue_multiplier_next   = '0;
    issue_multiplicand_next = '0;
    case (state_reg)
      ST_IDLE: begin
        if (job_take) begin
          issue_instruction_next = mac_instr(job_mode, OP_CLR);
        end
      end
      ST_CLR: begin
        // First RUN cycle has no pair yet, so feed mac a harmless zero add
        issue_instruction_next = mac_instr(mode_reg, (cnt_reg == '0) ? drain_op : OP_ACC);
      end
      ST_RUN: begin
        if (op_take) begin
          issue_instruction_next  = mac_instr(mode_reg, first_reg ? OP_LOAD : OP_ACC);
          issue_multiplier_next   = op_a;
          issue_multiplicand_next = op_b;
        end else begin
          issue_hold_next = 1'b1;
        end
      end
      ST_SAT: begin
        issue_instruction_next = mac_instr(mode_reg, OP_SAT);
      end
      ST_DRAIN, ST_DONE: begin
        issue_instruction_next = mac_instr(mode_reg, drain_op);
      end
      default: begin
        issue_instruction_next = mac_instr(MODE_WIDE, OP_CLR);
      end
    endcase
  end

  mac_issue_reg u_issue (
    .clk               (clk),
    .reset             (reset),
    .hold              (issue_hold_next),
    .next_instruction  (issue_instruction_next),
    .next_multiplier   (issue_multiplier_next),
    .next_multiplicand (issue_multiplicand_next),
    .instruction       (mac_instruction),
    .multiplier        (mac_multiplier),
    .multiplicand      (mac_multiplicand),
    .stall             (mac_stall)
  );

  // Job sequencing FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      cnt_reg         <= '0;
      mode_reg        <= MODE_WIDE;
      sat_reg         <= 1'b0;
      first_reg       <= 1'b0;
      drain_cnt_reg   <= '0;
      job_ready_reg   <= 1'b0;
      op_ready_reg    <= 1'b0;
      res_valid_reg   <= 1'b0;
      res_result_reg  <= '0;
      res_protect_reg <= '0;
      busy_reg        <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (job_take) begin
            mode_reg      <= job_mode;
            sat_reg       <= job_sat;
            cnt_reg       <= job_len;
            job_ready_reg <= 1'b0;
            busy_reg      <= 1'b1;
            state_reg     <= ST_CLR;
          end else begin
            job_ready_reg <= 1'b1;
          end
        end
        ST_CLR: begin
          first_reg <= 1'b1;
          if (cnt_reg == '0) begin
            drain_cnt_reg <= DRAIN_LOAD;
            state_reg     <= ST_DRAIN;
          end else begin
            op_ready_reg <= 1'b1;
            state_reg    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (op_take) begin
            first_reg <= 1'b0;
            if (cnt_reg != '0) begin
              cnt_reg <= cnt_reg - LEN_W'(1);
            end
            if (cnt_reg == LEN_W'(1)) begin
              op_ready_reg  <= 1'b0;
              drain_cnt_reg <= DRAIN_LOAD;
              state_reg     <= sat_reg ? ST_SAT : ST_DRAIN;
            end
          end
        end
        ST_SAT: begin
          drain_cnt_reg <= DRAIN_LOAD;
          state_reg     <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (drain_cnt_reg == '0) begin
            res_result_reg  <= mac_result;
            res_protect_reg <= mac_protect;
            res_valid_reg   <= 1'b1;
            state_reg       <= ST_DONE;
          end else begin
            drain_cnt_reg <= drain_cnt_reg - DRAIN_W'(1);
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            res_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            job_ready_reg <= 1'b1;
            state_reg     <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign job_ready   = job_ready_reg;
  assign op_ready    = op_ready_reg;
  assign res_valid   = res_valid_reg;
  assign res_result  = res_result_reg;
  assign res_protect = res_protect_reg;
  assign busy        = busy_reg;

endmodule
